// File: rtl/tribus4a_arb.sv
// Round-robin write arbiter and sequencer for the 4-port tribus4a bus block.
// One owner per bounded burst, registered strobes, one turnaround cycle between owners.
module tribus4a_arb #(
   parameter int AW       = 7,
   parameter int DW       = 8,
   parameter int MAXBURST = 4
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic [3:0]      REQ,
   input  logic [4*DW-1:0] DIN,
   input  logic [4*AW-1:0] AIN,
   output logic [3:0]      GNT,
   output logic [1:0]      ENA,
   output logic            WREN1,
   output logic            WREN2,
   output logic            WREN3,
   output logic            WREN4,
   output logic [AW-1:0]   A,
   output logic [DW-1:0]   D,
   output logic            BUSY
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] XFER = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam logic [3:0] LASTCNT = 4'(MAXBURST - 1);

   logic [1:0] state;
   logic [1:0] ptr;
   logic [3:0] cnt;
   logic [3:0] wren;
   logic       winvalid;
   logic [1:0] winidx;
   logic       accept;

   // Scan from farthest to nearest so the first requester at or after ptr wins.
   always_comb begin
      winvalid = 1'b0;
      winidx   = ptr;
      for (int k = 3; k >= 0; k--) begin
         if (REQ[ptr + 2'(k)]) begin
            winvalid = 1'b1;
            winidx   = ptr + 2'(k);
         end
      end
   end

   assign accept = REQ[ENA];

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
         ptr   <= 2'd0;
         cnt   <= 4'd0;
         GNT   <= 4'b0000;
         ENA   <= 2'd0;
         wren  <= 4'b0000;
         A     <= '0;
         D     <= '0;
      end else begin
         case (state)
            IDLE: begin
               wren <= 4'b0000;
               if (winvalid) begin
                  GNT   <= 4'b0001 << winidx;
                  ENA   <= winidx;
                  cnt   <= 4'd0;
                  state <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  A    <= AIN[int'(ENA) * AW +: AW];
                  D    <= DIN[int'(ENA) * DW +: DW];
                  wren <= 4'b0001 << ENA;
                  if (cnt == LASTCNT) begin
                     state <= GAP;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end else begin
                  wren  <= 4'b0000;
                  state <= GAP;
               end
            end
            GAP: begin
               // The last word's strobe stays visible through this cycle.
               GNT   <= 4'b0000;
               ptr   <= ENA + 2'd1;
               wren  <= 4'b0000;
               state <= IDLE;
            end
            default: begin
               wren  <= 4'b0000;
               state <= IDLE;
            end
         endcase
      end
   end

   assign WREN1 = wren[0];
   assign WREN2 = wren[1];
   assign WREN3 = wren[2];
   assign WREN4 = wren[3];
   assign BUSY  = (state != IDLE);

endmodule
